// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single-ported, variable-latency memory between the instruction
// fetch requester (IF) and the data load/store requester (D). One transaction
// is in flight at a time: a request is granted in IDLE, the memory is driven
// from registers captured at the grant edge, and the owner gets a one-cycle
// response strobe when the memory signals completion.
//
// Arbitration: D wins simultaneous requests (it belongs to the older
// instruction), except that after MAX_DATA_STREAK consecutive D grants with IF
// waiting, the next grant goes to IF so fetch cannot starve.
//
// Optional feature (macro ARB_TIMEOUT_EN): a BUSY watchdog. After
// TIMEOUT_CYCLES busy cycles without mem_ready the owner receives rvalid with
// rdata=0, err pulses for one cycle and the arbiter returns to IDLE. Without
// the macro the arbiter waits indefinitely and err is tied low.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   if_req / if_addr           fetch request (held until if_gnt) and address
//   if_gnt                     fetch accepted this cycle (IDLE only)
//   if_rvalid / if_rdata       fetch complete strobe and instruction word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_gnt), store flag,
//                              address and store data
//   d_gnt                      data request accepted this cycle (IDLE only)
//   d_rvalid / d_rdata         load data valid / store ack; rdata 0 on store
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata / mem_ready      memory read data and completion strobe
//   err                        one-cycle timeout strobe
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;   // consecutive D grants while IF waited
  logic                busy;
  logic                done;     // memory completes the current op
  logic                timeout;  // watchdog aborts the current op

  assign busy = (state == BUSY_IF) || (state == BUSY_D);
  // Reset gates completion so an op aborted by reset never strobes rvalid.
  assign done = busy && mem_ready && !reset;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;

  // mem_ready in the limit cycle takes precedence over the abort.
  assign timeout = busy && !mem_ready && (to_cnt == TO_LIMIT) && !reset;

  // Watchdog: held at zero in IDLE so every op starts from zero, counts
  // busy cycles that end without mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= {TO_W{1'b0}};
    end else if (state == IDLE) begin
      to_cnt <= {TO_W{1'b0}};
    end else if (!mem_ready && (to_cnt != TO_LIMIT)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Grant decision: only in IDLE and outside reset. IF wins when the data
  // streak has hit its limit, otherwise D has priority.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset && (state == IDLE)) begin
      if (if_req && (streak == STREAK_MAX)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
      end
    end else begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end
  end

  // Response strobes for the current owner. A timed-out op returns rdata 0,
  // and a completed store returns 0 rather than whatever the bus carries.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = {DATA_W{1'b0}};
    d_rvalid  = 1'b0;
    d_rdata   = {DATA_W{1'b0}};
    err       = timeout;
    case (state)
      BUSY_IF: begin
        if (done) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end else if (timeout) begin
          if_rvalid = 1'b1;
          if_rdata  = {DATA_W{1'b0}};
        end else begin
          if_rvalid = 1'b0;
          if_rdata  = {DATA_W{1'b0}};
        end
      end
      BUSY_D: begin
        if (done) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_we ? {DATA_W{1'b0}} : mem_rdata;
        end else if (timeout) begin
          d_rvalid = 1'b1;
          d_rdata  = {DATA_W{1'b0}};
        end else begin
          d_rvalid = 1'b0;
          d_rdata  = {DATA_W{1'b0}};
        end
      end
      default: begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
      end
    endcase
  end

  // Sequencer: captures the winner's command at the grant edge, holds the
  // memory command stable while busy and tracks the data-grant streak.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= {STREAK_W{1'b0}};
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (d_gnt) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // The streak only matters while fetch is actually waiting.
            if (!if_req) begin
              streak <= {STREAK_W{1'b0}};
            end else if (streak != STREAK_MAX) begin
              streak <= streak + STREAK_ONE;
            end else begin
              streak <= streak;
            end
          end else if (if_gnt) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= {DATA_W{1'b0}};
            streak    <= {STREAK_W{1'b0}};
          end else begin
            state <= IDLE;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (done || timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            state <= state;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios (reset, single fetch, D-over-IF priority, streak limit,
// reset mid-op, optional watchdog) followed by a randomized phase in which the
// bench acts as requesters and memory. The reference model tracks pending
// requests, the data streak and a sparse memory image; expected grants,
// commands and read data are derived from those alone.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int MAX_DATA_STREAK = 4;
  localparam int TIMEOUT_CYCLES  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mem_model [logic [31:0]];
  bit          pend_if, pend_d, p_d_we;
  logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
  int          streak;
  bit          win_if, win_d, o_is_d, o_we, rdy;
  logic [31:0] o_addr, o_wdata, exp_rd;
  int          lat;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_DATA_STREAK(MAX_DATA_STREAK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_flags"}, {57'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err}, 64'd0);
    chk({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    else return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet("reset_idle");
      next_cycle();
    end

    // Single fetch
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("fetch_gnt", 64'(if_gnt), 64'd1);
    chk("fetch_no_dgnt", 64'(d_gnt), 64'd0);
    chk("fetch_memreq_c0", 64'(mem_req), 64'd0);
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("fetch_memreq_c1", 64'(mem_req), 64'd1);
    chk("fetch_maddr", 64'(mem_addr), 64'h10);
    chk("fetch_mwe", 64'(mem_we), 64'd0);
    chk("fetch_rvalid", 64'(if_rvalid), 64'd1);
    chk("fetch_rdata", 64'(if_rdata), 64'h0050_0093);
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("fetch_done_memreq", 64'(mem_req), 64'd0);
    chk("fetch_done_rvalid", 64'(if_rvalid), 64'd0);
    next_cycle();

    // Simultaneous requests: D (store) first, IF in the next IDLE slot
    if_req = 1'b1; if_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD;
    @(negedge clk);
    chk("simul_dgnt", 64'(d_gnt), 64'd1);
    chk("simul_no_ifgnt", 64'(if_gnt), 64'd0);
    next_cycle();
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("simul_mwe", 64'(mem_we), 64'd1);
    chk("simul_mwdata", 64'(mem_wdata), 64'hDEAD);
    chk("simul_maddr", 64'(mem_addr), 64'h100);
    chk("simul_d_ack", 64'(d_rvalid), 64'd1);
    chk("simul_store_rdata0", 64'(d_rdata), 64'd0);
    chk("simul_no_gnt_busy", 64'(if_gnt), 64'd0);
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("simul_ifgnt_next", 64'(if_gnt), 64'd1);
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("simul_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("simul_if_rdata", 64'(if_rdata), 64'h13);
    chk("simul_if_mwe", 64'(mem_we), 64'd0);
    next_cycle();
    mem_ready = 1'b0;

    // Streak limit: D,D,D,D,IF,D with both requests held
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int op = 0; op < 6; op++) begin
      @(negedge clk);
      chk($sformatf("streak_ifgnt%0d", op), 64'(if_gnt), 64'(op == 4));
      chk($sformatf("streak_dgnt%0d", op), 64'(d_gnt), 64'(op != 4));
      next_cycle();
      mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(op);
      @(negedge clk);
      chk($sformatf("streak_ifrv%0d", op), 64'(if_rvalid), 64'(op == 4));
      chk($sformatf("streak_drv%0d", op), 64'(d_rvalid), 64'(op != 4));
      next_cycle();
      mem_ready = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort: rvalid/err exactly TIMEOUT_CYCLES after mem_req rises
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("to_dgnt", 64'(d_gnt), 64'd1);
    next_cycle();
    d_req = 1'b0;
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait_memreq%0d", k), 64'(mem_req), 64'd1);
      chk($sformatf("to_wait_rv_err%0d", k), {62'd0, d_rvalid, err}, 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_fire_rvalid", 64'(d_rvalid), 64'd1);
    chk("to_fire_rdata", 64'(d_rdata), 64'd0);
    chk("to_fire_err", 64'(err), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("to_after", {61'd0, mem_req, err, d_rvalid}, 64'd0);
    next_cycle();

    // mem_ready in the limit cycle is a normal completion
    d_req = 1'b1; d_addr = 32'h304;
    @(negedge clk);
    chk("to2_dgnt", 64'(d_gnt), 64'd1);
    next_cycle();
    d_req = 1'b0;
    repeat (TIMEOUT_CYCLES) next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("to2_rvalid", 64'(d_rvalid), 64'd1);
    chk("to2_rdata", 64'(d_rdata), 64'hCAFE_F00D);
    chk("to2_no_err", 64'(err), 64'd0);
    next_cycle();
    mem_ready = 1'b0;
`endif

    // Reset in the middle of a stalled load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    @(negedge clk);
    chk("rst_mid_dgnt", 64'(d_gnt), 64'd1);
    next_cycle();
    d_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_busy%0d", k), 64'(mem_req), 64'd1);
      chk($sformatf("rst_mid_norv%0d", k), 64'(d_rvalid), 64'd0);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_cycle_norv", 64'(d_rvalid), 64'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid_after");
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_quiet("idle_ready_ignored");
    next_cycle();
    mem_ready = 1'b0;

    // Randomized phase against the reference model
    pend_if = 1'b0; pend_d = 1'b0; streak = 0;
    for (int op = 0; op < 300; op++) begin
      if (!pend_if && ($urandom_range(0, 1) == 1)) begin
        pend_if = 1'b1; p_if_addr = 32'($urandom_range(0, 7) * 4);
      end
      if (!pend_d && ($urandom_range(0, 1) == 1)) begin
        pend_d = 1'b1; p_d_we = 1'($urandom_range(0, 1));
        p_d_addr = 32'($urandom_range(0, 7) * 4); p_d_wdata = $urandom;
      end
      if_req = pend_if; if_addr = p_if_addr;
      d_req = pend_d; d_we = p_d_we; d_addr = p_d_addr; d_wdata = p_d_wdata;
      mem_ready = 1'($urandom_range(0, 3) == 0); mem_rdata = $urandom;
      win_d  = pend_d && !(pend_if && (streak == MAX_DATA_STREAK));
      win_if = pend_if && !win_d;
      @(negedge clk);
      chk("rnd_ifgnt", 64'(if_gnt), 64'(win_if));
      chk("rnd_dgnt", 64'(d_gnt), 64'(win_d));
      chk("rnd_idle_quiet", {61'd0, if_rvalid, d_rvalid, mem_req}, 64'd0);
      next_cycle();
      mem_ready = 1'b0;
      if (win_d || win_if) begin
        if (win_d) begin
          streak = pend_if ? ((streak < MAX_DATA_STREAK) ? streak + 1 : streak) : 0;
          o_is_d = 1'b1; o_we = p_d_we; o_addr = p_d_addr; o_wdata = p_d_wdata;
          pend_d = 1'b0;
        end else begin
          streak = 0;
          o_is_d = 1'b0; o_we = 1'b0; o_addr = p_if_addr; o_wdata = 32'd0;
          pend_if = 1'b0;
        end
        lat = $urandom_range(0, 3);
        for (int k = 0; k <= lat; k++) begin
          if (!pend_if && ($urandom_range(0, 3) == 0)) begin
            pend_if = 1'b1; p_if_addr = 32'($urandom_range(0, 7) * 4);
          end
          if_req = pend_if; if_addr = p_if_addr; d_req = pend_d;
          rdy = (k == lat);
          mem_ready = rdy;
          mem_rdata = (rdy && !o_we) ? mem_read(o_addr) : $urandom;
          exp_rd = o_we ? 32'd0 : mem_read(o_addr);
          @(negedge clk);
          chk("rnd_memreq", 64'(mem_req), 64'd1);
          chk("rnd_maddr", 64'(mem_addr), 64'(o_addr));
          chk("rnd_mwe", 64'(mem_we), 64'(o_we));
          if (o_is_d) chk("rnd_mwdata", 64'(mem_wdata), 64'(o_wdata));
          chk("rnd_busy_nogrant", {62'd0, if_gnt, d_gnt}, 64'd0);
          chk("rnd_ifrv", 64'(if_rvalid), 64'(rdy && !o_is_d));
          chk("rnd_drv", 64'(d_rvalid), 64'(rdy && o_is_d));
          if (rdy && o_is_d) chk("rnd_drdata", 64'(d_rdata), 64'(exp_rd));
          if (rdy && !o_is_d) chk("rnd_ifrdata", 64'(if_rdata), 64'(exp_rd));
          if (rdy && o_we) mem_model[o_addr] = o_wdata;
          next_cycle();
        end
        mem_ready = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
